// File: rtl/pn_injection_scheduler.sv
// Pipeline stage feeding permutationNetwork: registers the four link flits and injects the
// oldest queued local flit into the lowest free slot. Optional feature macro: INJ_STARVATION_EN.
`ifndef WIDTH_INTERNAL
`define WIDTH_INTERNAL 32
`endif

module pn_injection_scheduler #(
  parameter int FLIT_W       = `WIDTH_INTERNAL,
  parameter int TIME_LSB     = 0,
  parameter int TIME_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FLIT_W-1:0]             in_flit0,
  input  logic [FLIT_W-1:0]             in_flit1,
  input  logic [FLIT_W-1:0]             in_flit2,
  input  logic [FLIT_W-1:0]             in_flit3,
  input  logic                          in_vld0,
  input  logic                          in_vld1,
  input  logic                          in_vld2,
  input  logic                          in_vld3,
  input  logic [FLIT_W-1:0]             inj_flit,
  input  logic                          inj_valid,
  output logic                          inj_ready,
  output logic [FLIT_W-1:0]             pn_din0,
  output logic [FLIT_W-1:0]             pn_din1,
  output logic [FLIT_W-1:0]             pn_din2,
  output logic [FLIT_W-1:0]             pn_din3,
  output logic                          pn_vld0,
  output logic                          pn_vld1,
  output logic                          pn_vld2,
  output logic                          pn_vld3,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          starve
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TIME_W-1:0] cycle_cnt;
  logic [FLIT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;
  logic [FLIT_W-1:0] push_flit;
  logic [3:0]        link_vld;
  logic [FLIT_W-1:0] link_flit [4];
  logic [FLIT_W-1:0] slot_flit [4];
  logic [3:0]        slot_vld;
  logic              placed;

  assign link_vld     = {in_vld3, in_vld2, in_vld1, in_vld0};
  assign link_flit[0] = in_flit0;
  assign link_flit[1] = in_flit1;
  assign link_flit[2] = in_flit2;
  assign link_flit[3] = in_flit3;

  // Ready comes from registered occupancy only, so a same-cycle pop never raises it.
  assign inj_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push      = inj_valid & inj_ready;
  assign pop       = (fifo_count != {CNT_W{1'b0}}) & ~(&link_vld);

  // Stamp the pushed flit's age field with this cycle's counter value.
  always_comb begin
    push_flit = inj_flit;
    push_flit[TIME_LSB +: TIME_W] = cycle_cnt;
  end

  // Build next slot contents: link flits pass through, head fills the lowest idle slot.
  always_comb begin
    slot_vld = link_vld;
    placed   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slot_flit[i] = link_vld[i] ? link_flit[i] : {FLIT_W{1'b0}};
      if (pop && !placed && !link_vld[i]) begin
        slot_flit[i] = mem[rd_ptr];
        slot_vld[i]  = 1'b1;
        placed       = 1'b1;
      end else begin
        placed       = placed;
      end
    end
  end

  // Cycle counter, FIFO pointers/occupancy and the registered network slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt  <= {TIME_W{1'b0}};
      rd_ptr     <= {PTR_W{1'b0}};
      wr_ptr     <= {PTR_W{1'b0}};
      fifo_count <= {CNT_W{1'b0}};
      pn_din0    <= {FLIT_W{1'b0}};
      pn_din1    <= {FLIT_W{1'b0}};
      pn_din2    <= {FLIT_W{1'b0}};
      pn_din3    <= {FLIT_W{1'b0}};
      pn_vld0    <= 1'b0;
      pn_vld1    <= 1'b0;
      pn_vld2    <= 1'b0;
      pn_vld3    <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + TIME_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      pn_din0 <= slot_flit[0];
      pn_din1 <= slot_flit[1];
      pn_din2 <= slot_flit[2];
      pn_din3 <= slot_flit[3];
      pn_vld0 <= slot_vld[0];
      pn_vld1 <= slot_vld[1];
      pn_vld2 <= slot_vld[2];
      pn_vld3 <= slot_vld[3];
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= push_flit;
    end
  end

`ifdef INJ_STARVATION_EN
  localparam int BLK_W = $clog2(STARVE_LIMIT + 1);

  logic [BLK_W-1:0] blk_cnt;
  logic [BLK_W-1:0] blk_next;

  // Count cycles where a queued head could not be injected, saturating at the limit.
  always_comb begin
    if (pop || (fifo_count == {CNT_W{1'b0}})) begin
      blk_next = {BLK_W{1'b0}};
    end else if (blk_cnt < BLK_W'(STARVE_LIMIT)) begin
      blk_next = blk_cnt + BLK_W'(1);
    end else begin
      blk_next = blk_cnt;
    end
  end

  // Blocked-cycle register and registered starvation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt <= {BLK_W{1'b0}};
      starve  <= 1'b0;
    end else begin
      blk_cnt <= blk_next;
      starve  <= (blk_next == BLK_W'(STARVE_LIMIT));
    end
  end
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_pn_injection_scheduler.sv
// Directed self-checking bench for pn_injection_scheduler (TIME_W=8, TIME_LSB=0, depth 4).
module tb_pn_injection_scheduler;

  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] in_flit0, in_flit1, in_flit2, in_flit3;
  logic          in_vld0, in_vld1, in_vld2, in_vld3;
  logic [FW-1:0] inj_flit;
  logic          inj_valid;
  logic          inj_ready;
  logic [FW-1:0] pn_din0, pn_din1, pn_din2, pn_din3;
  logic          pn_vld0, pn_vld1, pn_vld2, pn_vld3;
  logic [2:0]    fifo_count;
  logic          starve;

  int errors = 0;
  int checks = 0;
  int tcnt   = 0;

  always #5 clk = ~clk;

  pn_injection_scheduler #(
    .FLIT_W(FW), .TIME_LSB(0), .TIME_W(8), .FIFO_DEPTH(4), .STARVE_LIMIT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .in_flit0(in_flit0), .in_flit1(in_flit1), .in_flit2(in_flit2), .in_flit3(in_flit3),
    .in_vld0(in_vld0), .in_vld1(in_vld1), .in_vld2(in_vld2), .in_vld3(in_vld3),
    .inj_flit(inj_flit), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .pn_din0(pn_din0), .pn_din1(pn_din1), .pn_din2(pn_din2), .pn_din3(pn_din3),
    .pn_vld0(pn_vld0), .pn_vld1(pn_vld1), .pn_vld2(pn_vld2), .pn_vld3(pn_vld3),
    .fifo_count(fifo_count), .starve(starve)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcnt = (tcnt + 1) % 256;
  endtask

  task automatic links(input logic [3:0] v, input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                       input logic [FW-1:0] f2, input logic [FW-1:0] f3);
    {in_vld3, in_vld2, in_vld1, in_vld0} = v;
    in_flit0 = f0; in_flit1 = f1; in_flit2 = f2; in_flit3 = f3;
  endtask

  function automatic logic [FW-1:0] stamp(input logic [FW-1:0] f, input int t);
    logic [FW-1:0] r;
    r = f;
    r[7:0] = t[7:0];
    return r;
  endfunction

  function automatic logic [3:0] vld();
    return {pn_vld3, pn_vld2, pn_vld1, pn_vld0};
  endfunction

  // One accepted push; exp receives the flit as it should later appear on a slot.
  task automatic push(input logic [FW-1:0] f, output logic [FW-1:0] exp);
    inj_flit  = f;
    inj_valid = 1'b1;
    exp       = stamp(f, tcnt);
    tick();
    inj_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    inj_valid = 1'b0;
    links(4'b0000, '0, '0, '0, '0);
    tick();
    reset = 1'b0;
    tcnt  = 0;
  endtask

  logic [FW-1:0] e, q0, q1, q2, q3, q4;

  initial begin
    inj_flit = '0;
    do_reset();
    check("rst_vld", vld(), 4'b0000);
    check("rst_count", fifo_count, 3'd0);
    check("rst_ready", inj_ready, 1'b1);
    check("rst_starve", starve, 1'b0);
    check("rst_din0", pn_din0, 32'h0);

    // pass-through of four distinct link flits
    links(4'b1111, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    tick();
    check("pt_din0", pn_din0, 32'h11111111);
    check("pt_din1", pn_din1, 32'h22222222);
    check("pt_din2", pn_din2, 32'h33333333);
    check("pt_din3", pn_din3, 32'h44444444);
    check("pt_vld", vld(), 4'b1111);
    links(4'b0000, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD);
    tick();
    check("zero_vld", vld(), 4'b0000);
    check("zero_din0", pn_din0, 32'h0);
    check("zero_din3", pn_din3, 32'h0);

    // slot pick: flit queued at counter 5 lands in slot 1
    do_reset();
    repeat (5) tick();
    links(4'b1111, 32'h1, 32'h2, 32'h3, 32'h4);
    push(32'hDEADBEFF, e);
    check("pick_count1", fifo_count, 3'd1);
    links(4'b0101, 32'h01010101, 32'h0BAD0001, 32'h03030303, 32'h0BAD0003);
    tick();
    check("pick_din1", pn_din1, 32'hDEADBE05);
    check("pick_vld", vld(), 4'b0111);
    check("pick_din0", pn_din0, 32'h01010101);
    check("pick_din3", pn_din3, 32'h0);
    check("pick_count0", fifo_count, 3'd0);

    // no bypass: push into empty FIFO with free slots waits one cycle
    links(4'b0000, '0, '0, '0, '0);
    push(32'h12345600, e);
    check("nobyp_vld", vld(), 4'b0000);
    check("nobyp_count", fifo_count, 3'd1);
    tick();
    check("nobyp_din0", pn_din0, e);
    check("nobyp_vld2", vld(), 4'b0001);

    // full FIFO, then single injection, push+pop, drain order
    links(4'b1111, 32'h5, 32'h6, 32'h7, 32'h8);
    push(32'hF0000100, q0);
    push(32'hF0000200, q1);
    push(32'hF0000300, q2);
    push(32'hF0000400, q3);
    check("full_count", fifo_count, 3'd4);
    check("full_ready", inj_ready, 1'b0);
    inj_flit = 32'hBAD00000; inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    check("full_hold", fifo_count, 3'd4);
    check("full_vld", vld(), 4'b1111);
    links(4'b1011, 32'h5, 32'h6, 32'h7, 32'h8);
    tick();
    check("full_inj_din2", pn_din2, q0);
    check("full_inj_vld", vld(), 4'b1111);
    check("full_inj_count", fifo_count, 3'd3);
    check("full_inj_ready", inj_ready, 1'b1);
    links(4'b1110, 32'h5, 32'h6, 32'h7, 32'h8);
    push(32'h0E0E0E00, q4);
    check("pp_din0", pn_din0, q1);
    check("pp_count", fifo_count, 3'd3);
    links(4'b0000, '0, '0, '0, '0);
    tick();
    check("drain_a", pn_din0, q2);
    tick();
    check("drain_b", pn_din0, q3);
    tick();
    check("drain_c", pn_din0, q4);
    check("drain_count", fifo_count, 3'd0);

    // reset with three queued flits discards them
    do_reset();
    links(4'b1111, 32'h9, 32'hA, 32'hB, 32'hC);
    push(32'h10000000, e);
    push(32'h20000000, e);
    push(32'h30000000, e);
    check("mid_count3", fifo_count, 3'd3);
    reset = 1'b1;
    tick();
    check("mid_rst_count", fifo_count, 3'd0);
    check("mid_rst_vld", vld(), 4'b0000);
    check("mid_rst_din1", pn_din1, 32'h0);
    check("mid_rst_ready", inj_ready, 1'b1);
    reset = 1'b0; tcnt = 0;
    links(4'b0000, '0, '0, '0, '0);
    tick();
    check("mid_after_vld", vld(), 4'b0000);

    // counter wrap: stamps 255 then 0
    do_reset();
    repeat (255) tick();
    links(4'b1111, 32'h1, 32'h2, 32'h3, 32'h4);
    push(32'hAAAAAA11, e);
    push(32'hBBBBBB22, e);
    links(4'b0000, '0, '0, '0, '0);
    tick();
    check("wrap_255", pn_din0, 32'hAAAAAAFF);
    tick();
    check("wrap_0", pn_din0, 32'hBBBBBB00);

    // starvation
    do_reset();
    links(4'b1111, 32'h1, 32'h2, 32'h3, 32'h4);
    push(32'h5A5A5A00, e);
    repeat (15) tick();
    check("starve_15", starve, 1'b0);
    tick();
`ifdef INJ_STARVATION_EN
    check("starve_16", starve, 1'b1);
`else
    check("starve_16", starve, 1'b0);
`endif
    links(4'b1110, 32'h1, 32'h2, 32'h3, 32'h4);
    tick();
    check("starve_inj_din0", pn_din0, e);
    check("starve_clear", starve, 1'b0);
    check("starve_count", fifo_count, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
